// File: rtl/fpu_class_cvt.sv
// rtl/fpu_class_cvt.sv - FCLASS.S / FCVT.S.W / FCVT.S.WU slice with sticky inexact flag
module fpu_class_cvt #(
  parameter int FLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic [1:0]      op,
  input  logic [FLEN-1:0] rs1,
  input  logic            nx_clr,
  output logic [FLEN-1:0] out,
  output logic            nx,
  output logic            nx_sticky
);

  localparam logic [1:0] OP_CLASS = 2'd0;
  localparam logic [1:0] OP_CVT_W = 2'd1;
  localparam logic [1:0] OP_CVT_WU = 2'd2;

  // Float field view of rs1 for classification
  logic        f_sign;
  logic [7:0]  f_exp;
  logic [22:0] f_frac;
  logic [9:0]  class_res;

  assign f_sign = rs1[31];
  assign f_exp  = rs1[30:23];
  assign f_frac = rs1[22:0];

  // One-hot class mask; NaN classes deliberately ignore the sign
  always_comb begin
    class_res = '0;
    if (f_exp == 8'hFF) begin
      if (f_frac == 23'd0)  class_res[f_sign ? 0 : 7] = 1'b1;
      else if (f_frac[22])  class_res[9] = 1'b1;
      else                  class_res[8] = 1'b1;
    end else if (f_exp == 8'h00) begin
      if (f_frac == 23'd0)  class_res[f_sign ? 3 : 4] = 1'b1;
      else                  class_res[f_sign ? 2 : 5] = 1'b1;
    end else begin
      class_res[f_sign ? 1 : 6] = 1'b1;
    end
  end

  // Integer-to-float datapath
  logic        cvt_sign;
  logic [31:0] mag;
  logic [4:0]  lead_pos;
  logic [31:0] frac_full;
  logic [22:0] mant;
  logic        guard;
  logic        stk;
  logic        round_up;
  logic [23:0] mant_rnd;
  logic [7:0]  exp_base;
  logic [7:0]  cvt_exp;
  logic [22:0] cvt_frac;
  logic [31:0] cvt_res;
  logic        cvt_nx;

  // Two's-complement negate stays in 32 bits: 0x80000000 reads back as 2^31 unsigned
  assign cvt_sign = (op == OP_CVT_W) & rs1[31];
  assign mag      = cvt_sign ? (~rs1 + 32'd1) : rs1;

  // Leading-one position; highest set bit wins
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lead_pos = i[4:0];
    end
  end

  // Shifting by 32-p pushes the implicit one off the top, leaving only fraction bits
  assign frac_full = mag << (6'd32 - {1'b0, lead_pos});
  assign mant      = frac_full[31:9];
  assign guard     = frac_full[8];
  assign stk       = |frac_full[7:0];
  assign round_up  = guard & (stk | mant[0]);
  assign mant_rnd  = {1'b0, mant} + {23'd0, round_up};
  assign exp_base  = 8'd127 + {3'd0, lead_pos};
  assign cvt_exp   = exp_base + {7'd0, mant_rnd[23]};
  assign cvt_frac  = mant_rnd[23] ? 23'd0 : mant_rnd[22:0];
  assign cvt_res   = (mag == 32'd0) ? 32'd0 : {cvt_sign, cvt_exp, cvt_frac};
  assign cvt_nx    = guard | stk;

  // Result mux into the FPU writeback path
  always_comb begin
    out = '0;
    nx  = 1'b0;
    case (op)
      OP_CLASS:  out = {22'd0, class_res};
      OP_CVT_W,
      OP_CVT_WU: begin
        out = cvt_res;
        nx  = cvt_nx;
      end
      default: begin
        out = '0;
        nx  = 1'b0;
      end
    endcase
  end

  // Accumulated inexact for fcsr.NX; a same-cycle set beats a clear
  always_ff @(posedge clk) begin
    if (!resetn)       nx_sticky <= 1'b0;
    else if (en && nx) nx_sticky <= 1'b1;
    else if (nx_clr)   nx_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_fpu_class_cvt.sv
// tb/tb_fpu_class_cvt.sv - randomized model-based bench for fpu_class_cvt
module tb_fpu_class_cvt;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic        nx_clr;
  logic [31:0] out;
  logic        nx;
  logic        nx_sticky;

  int checks = 0;
  int errors = 0;
  logic exp_sticky = 1'b0;

  fpu_class_cvt #(.FLEN(32)) dut (
    .clk(clk), .resetn(resetn), .en(en), .op(op), .rs1(rs1),
    .nx_clr(nx_clr), .out(out), .nx(nx), .nx_sticky(nx_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {nx, out}, computed with plain integer arithmetic
  function automatic logic [32:0] ref_model(input logic [1:0] o, input logic [31:0] x);
    logic [31:0] r;
    logic        inx;
    logic        s;
    int          ex, idx, p, e, sh;
    longint      fr, mag, sig, rem, half;
    r = 32'd0;
    inx = 1'b0;
    if (o == 2'd0) begin
      s  = x[31];
      ex = int'(x[30:23]);
      fr = longint'(x[22:0]);
      if (ex == 255 && fr == 0)      idx = s ? 0 : 7;
      else if (ex == 255 && fr >= 64'h400000) idx = 9;
      else if (ex == 255)            idx = 8;
      else if (ex == 0 && fr == 0)   idx = s ? 3 : 4;
      else if (ex == 0)              idx = s ? 2 : 5;
      else                           idx = s ? 1 : 6;
      r = 32'd1 << idx;
    end else if (o == 2'd1 || o == 2'd2) begin
      if (o == 2'd1) begin
        mag = longint'($signed(x));
        s   = (mag < 0);
        if (mag < 0) mag = -mag;
      end else begin
        mag = longint'(x);
        s   = 1'b0;
      end
      if (mag != 0) begin
        p = 0;
        for (int i = 0; i <= 32; i++) if (mag >= (longint'(1) << i)) p = i;
        e = 127 + p;
        if (p <= 23) begin
          sig = mag << (23 - p);
        end else begin
          sh   = p - 23;
          sig  = mag >> sh;
          rem  = mag - (sig << sh);
          half = longint'(1) << (sh - 1);
          if (rem > half || (rem == half && (sig % 2) == 1)) sig = sig + 1;
          inx = (rem != 0);
        end
        if (sig == (longint'(1) << 24)) begin
          sig = longint'(1) << 23;
          e = e + 1;
        end
        r = {s, 8'(e), 23'(sig)};
      end
    end
    return {inx, r};
  endfunction

  function automatic logic ref_nx(input logic [1:0] o, input logic [31:0] x);
    logic [32:0] t;
    t = ref_model(o, x);
    return t[32];
  endfunction

  // Sticky-flag model advanced on each rising edge
  always @(posedge clk) begin
    if (!resetn)                    exp_sticky <= 1'b0;
    else if (en && ref_nx(op, rs1)) exp_sticky <= 1'b1;
    else if (nx_clr)                exp_sticky <= 1'b0;
  end

  // Compare every cycle, mid-period
  always @(negedge clk) begin
    logic [32:0] m;
    m = ref_model(op, rs1);
    checks++;
    if (out !== m[31:0] || nx !== m[32]) begin
      errors++;
      $display("FAIL model_out op=%0d rs1=%h: got out=%h nx=%b, expected out=%h nx=%b",
               op, rs1, out, nx, m[31:0], m[32]);
    end
    checks++;
    if (nx_sticky !== exp_sticky) begin
      errors++;
      $display("FAIL model_sticky: got %b, expected %b", nx_sticky, exp_sticky);
    end
  end

  task automatic lit(input string name, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] eo, input logic enx);
    @(posedge clk); #1;
    op = o; rs1 = x; en = 1'b0; nx_clr = 1'b0;
    #2;
    checks++;
    if (out !== eo || nx !== enx) begin
      errors++;
      $display("FAIL %s: got out=%h nx=%b, expected out=%h nx=%b", name, out, nx, eo, enx);
    end
  endtask

  task automatic stick(input string name, input logic e, input logic clr, input logic [1:0] o,
                       input logic [31:0] x, input logic rn, input logic exp_v);
    @(posedge clk); #1;
    en = e; nx_clr = clr; op = o; rs1 = x; resetn = rn;
    @(posedge clk); #1;
    en = 1'b0; nx_clr = 1'b0; resetn = 1'b1;
    checks++;
    if (nx_sticky !== exp_v) begin
      errors++;
      $display("FAIL %s: got nx_sticky=%b, expected %b", name, nx_sticky, exp_v);
    end
  endtask

  logic [31:0] cls_in  [7] = '{32'hFF800000, 32'h80000000, 32'h00000001, 32'h3F800000,
                               32'h7F800000, 32'h7F800001, 32'h7FC00000};
  logic [31:0] cls_out [7] = '{32'h001, 32'h008, 32'h020, 32'h040, 32'h080, 32'h100, 32'h200};
  logic [31:0] edges   [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00FFFFFF};
  logic [7:0]  fexps   [4] = '{8'h00, 8'hFF, 8'h7F, 8'h01};

  initial begin
    resetn = 1'b0; en = 1'b0; op = 2'd0; rs1 = 32'd0; nx_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (nx_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky: got %b, expected 0", nx_sticky);
    end
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) lit("fclass", 2'd0, cls_in[i], cls_out[i], 1'b0);
    lit("cvtw_0",        2'd1, 32'h00000000, 32'h00000000, 1'b0);
    lit("cvtw_1",        2'd1, 32'h00000001, 32'h3F800000, 1'b0);
    lit("cvtw_m1",       2'd1, 32'hFFFFFFFF, 32'hBF800000, 1'b0);
    lit("cvtw_min",      2'd1, 32'h80000000, 32'hCF000000, 1'b0);
    lit("cvtw_tie_even", 2'd1, 32'h01000001, 32'h4B800000, 1'b1);
    lit("cvtw_tie_up",   2'd1, 32'h01000003, 32'h4B800002, 1'b1);
    lit("cvtw_carry",    2'd1, 32'h7FFFFFFF, 32'h4F000000, 1'b1);
    lit("cvtwu_max",     2'd2, 32'hFFFFFFFF, 32'h4F800000, 1'b1);
    lit("cvtwu_2p31",    2'd2, 32'h80000000, 32'h4F000000, 1'b0);
    lit("cvtwu_24b",     2'd2, 32'h00FFFFFF, 32'h4B7FFFFF, 1'b0);
    lit("reserved",      2'd3, 32'h7FFFFFFF, 32'h00000000, 1'b0);

    stick("sticky_set",      1'b1, 1'b0, 2'd1, 32'h7FFFFFFF, 1'b1, 1'b1);
    stick("sticky_set_wins", 1'b1, 1'b1, 2'd1, 32'h7FFFFFFF, 1'b1, 1'b1);
    stick("sticky_clr",      1'b0, 1'b1, 2'd0, 32'h00000000, 1'b1, 1'b0);
    stick("sticky_en0",      1'b0, 1'b0, 2'd1, 32'h7FFFFFFF, 1'b1, 1'b0);
    stick("sticky_reset_a",  1'b1, 1'b0, 2'd2, 32'hFFFFFFFF, 1'b1, 1'b1);
    stick("sticky_reset_b",  1'b0, 1'b0, 2'd0, 32'h00000000, 1'b0, 1'b0);

    for (int c = 0; c < 800; c++) begin
      int kind, p, sh;
      logic [31:0] x;
      @(posedge clk); #1;
      resetn = ($urandom_range(0, 49) != 0);
      en     = 1'($urandom_range(0, 1));
      nx_clr = ($urandom_range(0, 3) == 0);
      op     = 2'($urandom_range(0, 3));
      kind   = $urandom_range(0, 4);
      case (kind)
        0: x = $urandom;
        1: x = ($urandom & 32'h00FFFFFF) >> $urandom_range(0, 23);
        2: begin
          p  = $urandom_range(24, 31);
          sh = p - 23;
          x  = (32'd1 << p) | (($urandom & 32'h007FFFFF) << sh) | (32'd1 << (sh - 1));
          if ($urandom_range(0, 1) == 1) x = ~x + 32'd1;
        end
        3: x = {1'($urandom_range(0, 1)), fexps[$urandom_range(0, 3)],
                ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom)};
        default: x = edges[$urandom_range(0, 5)];
      endcase
      rs1 = x;
    end
    @(posedge clk); #1;
    resetn = 1'b1; en = 1'b0; nx_clr = 1'b0;
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
